// File: rtl/seq_mult_param_if.sv
// Start/done handshake bundle for the parametrised shift-add multiplier.
// The master drives the operands and start; the slave returns the product and status.
interface seq_mult_param_if #(
    parameter int unsigned WIDTH = 16
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic [2*WIDTH-1:0]     result;
    logic                   done;
    logic                   busy;

    modport master (
        output start, is_signed, A, B,
        input  result, done, busy
    );

    modport slave (
        input  start, is_signed, A, B,
        output result, done, busy
    );
endinterface

// File: rtl/seq_mult_param.sv
// Sequential shift-add WIDTHxWIDTH multiplier with signed/unsigned mode, a busy flag,
// and optional early exit once no multiplier bits remain.
module seq_mult_param #(
    parameter int unsigned WIDTH      = 16,
    parameter bit          EARLY_TERM = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    seq_mult_param_if.slave bus
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q,  mplr_d;
    logic [PW-1:0]      acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               neg_q,   neg_d;
    logic [PW-1:0]      result_q, result_d;
    logic               done_q;
    logic               busy_q;

    logic               a_neg_c;
    logic               b_neg_c;
    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;
    logic               accept_c;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits.
    assign a_neg_c  = bus.is_signed & bus.A[WIDTH-1];
    assign b_neg_c  = bus.is_signed & bus.B[WIDTH-1];
    assign a_mag_c  = a_neg_c ? WIDTH'(-bus.A) : bus.A;
    assign b_mag_c  = b_neg_c ? WIDTH'(-bus.B) : bus.B;
    assign accept_c = bus.start & ((state_q == S_IDLE) | (state_q == S_DONE));

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;

        case (state_q)
            S_RUN: begin
                acc_d   = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
                mcand_d = {mcand_q[PW-2:0], 1'b0};
                mplr_d  = {1'b0, mplr_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if ((cnt_q == CNT_W'(WIDTH - 1)) || (EARLY_TERM && (mplr_d == '0))) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = neg_q ? PW'(-acc_q) : acc_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: ;
        endcase

        // A new request overrides the DONE->IDLE return, giving back-to-back operation.
        if (accept_c) begin
            mcand_d = {{WIDTH{1'b0}}, a_mag_c};
            mplr_d  = b_mag_c;
            acc_d   = '0;
            cnt_d   = '0;
            neg_d   = bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            state_d = (EARLY_TERM && (b_mag_c == '0)) ? S_FIX : S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= (state_d == S_DONE);
            busy_q   <= (state_d == S_RUN) || (state_d == S_FIX);
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
endmodule
